key_sched_ctrl: RTL

Sequences the AES-128 round-key expander and owns the expanded key store. Accepts a new cipher key over a valid/ready handshake, starts the expander with a one-cycle enable pulse, and captures its 11 round keys into an internal register file. Serves round-key reads to two cipher cores through a round-robin arbiter, one read granted per cycle.

---
 rtl/key_sched_ctrl_if.sv | 55 +++++
 rtl/key_sched_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/key_sched_ctrl_if.sv
// ---------------------------------------------------------------------------
// key_sched_ctrl_if
// Bundles the three channels of the AES-128 key schedule controller:
//   key load    : key_in, key_valid -> key_ready
//   expander    : rk_en, rk_key -> expander; rk_round_key, rk_w_e,
//                 rk_round_no, rk_done <- expander
//   round reads : rd_req, rd_idx0, rd_idx1 -> rd_gnt, rd_rvalid, rd_data
//   status      : keys_valid, key_err
// Modports:
//   slave  - the controller (key_sched_ctrl)
//   master - the surrounding environment (key source, expander, cores)
// ---------------------------------------------------------------------------
interface key_sched_ctrl_if #(
  parameter int KEY_S = 128,
  parameter int IDX_W = 4
);
  logic [KEY_S-1:0] key_in;
  logic             key_valid;
  logic             key_ready;

  logic             rk_en;
  logic [KEY_S-1:0] rk_key;
  logic [KEY_S-1:0] rk_round_key;
  logic             rk_w_e;
  logic [IDX_W-1:0] rk_round_no;
  logic             rk_done;

  logic             keys_valid;
  logic             key_err;

  logic [1:0]       rd_req;
  logic [IDX_W-1:0] rd_idx0;
  logic [IDX_W-1:0] rd_idx1;
  logic [1:0]       rd_gnt;
  logic [1:0]       rd_rvalid;
  logic [KEY_S-1:0] rd_data;

  modport slave (
    input  key_in, key_valid,
    input  rk_round_key, rk_w_e, rk_round_no, rk_done,
    input  rd_req, rd_idx0, rd_idx1,
    output key_ready, rk_en, rk_key,
    output keys_valid, key_err,
    output rd_gnt, rd_rvalid, rd_data
  );

  modport master (
    output key_in, key_valid,
    output rk_round_key, rk_w_e, rk_round_no, rk_done,
    output rd_req, rd_idx0, rd_idx1,
    input  key_ready, rk_en, rk_key,
    input  keys_valid, key_err,
    input  rd_gnt, rd_rvalid, rd_data
  );
endinterface

// File: rtl/key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// key_sched_ctrl
// Sequences the AES-128 round-key expander and owns the expanded key store.
// A new cipher key is taken over key_valid/key_ready, the expander is started
// with a one-cycle rk_en pulse, and its NR+1 round keys are captured into an
// internal register file. Two cipher cores read round keys through a
// round-robin arbiter, one grant per cycle, data returned one cycle later.
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset
//   bus   - key_sched_ctrl_if.slave (key load, expander, read channels,
//           keys_valid / key_err status)
// ---------------------------------------------------------------------------
module key_sched_ctrl #(
  parameter int KEY_S = 128,
  parameter int NR    = 10,
  parameter int IDX_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  key_sched_ctrl_if.slave bus
);

  localparam int               CNT_W    = IDX_W + 1;
  localparam logic [IDX_W-1:0] NR_IDX   = IDX_W'(NR);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NR + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [CNT_W-1:0] r_wr_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_cnt_tot;

  logic             r_key_ready;
  logic             r_rk_en_p1;
  logic [KEY_S-1:0] r_rk_key;
  logic             r_keys_valid;
  logic             r_key_err;
  logic             r_rr;

  logic [KEY_S-1:0] r_store [0:NR];

  logic [1:0]       w_gnt;
  logic [IDX_W-1:0] w_gnt_idx;
  logic             w_idx_bad;
  logic [KEY_S-1:0] w_rd_word;
  logic [1:0]       r_rd_vld_p1;
  logic [KEY_S-1:0] r_rd_data_p1;

  logic             w_accept;
  logic             w_wr_hit;
  logic             w_wr_bad;
  logic             w_wr_ok;
  logic             w_done_hit;
  logic             w_done_good;

  // Write counter saturates so a runaway expander cannot wrap it back to a
  // value that looks like a complete key set.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Expander write / completion decode
  always_comb begin
    w_accept    = bus.key_valid & r_key_ready;
    w_wr_hit    = (r_state == ST_EXPAND) & bus.rk_w_e;
    w_wr_bad    = w_wr_hit & (bus.rk_round_no > NR_IDX);
    w_wr_ok     = w_wr_hit & ~w_wr_bad & ~reset;
    w_cnt_inc   = sat_inc(r_wr_cnt);
    // rk_done coincides with the final write, so that write is counted first
    w_cnt_tot   = w_wr_hit ? w_cnt_inc : r_wr_cnt;
    w_done_hit  = (r_state == ST_EXPAND) & bus.rk_done;
    w_done_good = w_done_hit & (w_cnt_tot == FULL_CNT);
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_READY: begin
        if (w_accept) w_state_nxt = ST_EXPAND;
      end
      ST_EXPAND: begin
        if (w_done_hit) w_state_nxt = w_done_good ? ST_READY : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Round-robin read arbiter; r_rr names the core that wins a tie
  always_comb begin
    w_gnt = 2'b00;
    if (r_keys_valid) begin
      if (&bus.rd_req) w_gnt = r_rr ? 2'b10 : 2'b01;
      else             w_gnt = bus.rd_req;
    end
    w_gnt_idx = w_gnt[1] ? bus.rd_idx1 : bus.rd_idx0;
    w_idx_bad = (|w_gnt) & (w_gnt_idx > NR_IDX);
    w_rd_word = w_idx_bad ? '0 : r_store[w_gnt_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Stage p0 -> p1: control, expander start pulse and registered read return
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key_ready  <= 1'b0;
      r_rk_en_p1   <= 1'b0;
      r_rk_key     <= '0;
      r_keys_valid <= 1'b0;
      r_key_err    <= 1'b0;
      r_rr         <= 1'b0;
      r_wr_cnt     <= '0;
      r_rd_vld_p1  <= 2'b00;
      r_rd_data_p1 <= '0;
    end else begin
      // Registered so key_ready stays low for the first cycle out of reset
      r_key_ready <= (w_state_nxt != ST_EXPAND);
      r_rk_en_p1  <= w_accept;

      if (w_accept) begin
        r_rk_key     <= bus.key_in;
        r_keys_valid <= 1'b0;
        r_wr_cnt     <= '0;
      end else begin
        if (w_wr_hit)    r_wr_cnt     <= w_cnt_inc;
        if (w_done_good) r_keys_valid <= 1'b1;
      end

      if (w_wr_bad | (w_done_hit & ~w_done_good) | w_idx_bad) r_key_err <= 1'b1;

      r_rd_vld_p1 <= w_gnt;
      if (|w_gnt) begin
        r_rd_data_p1 <= w_rd_word;
        // Tie priority passes to the core that was not just served
        r_rr         <= w_gnt[0];
      end
    end
  end

  // Key store: deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_store[bus.rk_round_no] <= bus.rk_round_key;
  end

  assign bus.key_ready  = r_key_ready;
  assign bus.rk_en      = r_rk_en_p1;
  assign bus.rk_key     = r_rk_key;
  assign bus.keys_valid = r_keys_valid;
  assign bus.key_err    = r_key_err;
  assign bus.rd_gnt     = w_gnt;
  assign bus.rd_rvalid  = r_rd_vld_p1;
  assign bus.rd_data    = r_rd_data_p1;

endmodule
